// File: rtl/uart_rx_pkt_ctrl_if.sv
// Signal bundle between the packet controller, the UART receiver and the payload consumer.
// master = the controller's view; slave = the receiver/consumer/config side.
interface uart_rx_pkt_ctrl_if;
    logic       enable;
    logic [2:0] cfg_baud;
    logic       cfg_load;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        input  enable, cfg_baud, cfg_load, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, pkt_ready,
        output baud_select, Rx_EN, pkt_data, pkt_valid, pkt_last, pkt_done, pkt_err, err_code, busy
    );
    modport slave (
        output enable, cfg_baud, cfg_load, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, pkt_ready,
        input  baud_select, Rx_EN, pkt_data, pkt_valid, pkt_last, pkt_done, pkt_err, err_code, busy
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive packet controller: SYNC, LEN, payload, XOR checksum framing onto a valid/ready stream.
// Optional inter-byte timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input logic               clk,
    input logic               reset,
    uart_rx_pkt_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_DONE, S_ERR
    } state_e;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [1:0] E_LINE = 2'b00, E_LEN = 2'b01, E_CSUM = 2'b10, E_ABORT = 2'b11;

    state_e     state_q, state_d;
    logic       rx_en_q, rxv_q;
    logic [2:0] baud_q;
    logic [7:0] cnt_q, cnt_d, csum_q, csum_d, data_q, data_d;
    logic       valid_q, valid_d, last_q, last_d;
    logic       done_q, err_q, busy_q;
    logic [1:0] code_q, code_d;
    logic       byte_evt, line_err, tmo_hit, go_err, busy_d;
    logic [1:0] err_c;

    assign byte_evt = bus.Rx_VALID & ~rxv_q;
    assign line_err = bus.Rx_FERROR | bus.Rx_PERROR;

`ifdef UART_RX_TIMEOUT_EN
    logic [31:0] tmo_q;
    assign tmo_hit = (tmo_q == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_q <= '0;
        else if (byte_evt || !(state_q inside {S_LEN, S_PAYLOAD, S_CSUM}))
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + 32'd1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        code_d  = code_q;
        go_err  = 1'b0;
        err_c   = code_q;

        if (valid_q && bus.pkt_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        unique case (state_q)
            S_IDLE: if (rx_en_q && bus.enable) state_d = S_HUNT;
            S_HUNT: begin
                if (!bus.enable)
                    state_d = S_IDLE;
                else if (byte_evt && !line_err && bus.Rx_DATA == SYNC_BYTE)
                    state_d = S_LEN;
            end
            S_LEN, S_PAYLOAD, S_CSUM: begin
                if (!bus.enable || tmo_hit) begin
                    go_err = 1'b1;
                    err_c  = E_ABORT;
                end else if (byte_evt) begin
                    if (line_err) begin
                        go_err = 1'b1;
                        err_c  = E_LINE;
                    end else if (state_q == S_LEN) begin
                        if (bus.Rx_DATA == 8'd0 || bus.Rx_DATA > MAX_LEN_B) begin
                            go_err = 1'b1;
                            err_c  = E_LEN;
                        end else begin
                            cnt_d   = bus.Rx_DATA;
                            csum_d  = bus.Rx_DATA;
                            state_d = S_PAYLOAD;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        // A byte arriving while the previous one is still unclaimed is an overrun.
                        if (valid_q && !bus.pkt_ready) begin
                            go_err = 1'b1;
                            err_c  = E_ABORT;
                        end else begin
                            data_d  = bus.Rx_DATA;
                            valid_d = 1'b1;
                            csum_d  = csum_q ^ bus.Rx_DATA;
                            cnt_d   = cnt_q - 8'd1;
                            last_d  = (cnt_q == 8'd1);
                            if (cnt_q == 8'd1) state_d = S_CSUM;
                        end
                    end else begin
                        if (bus.Rx_DATA == csum_q) begin
                            state_d = S_DONE;
                        end else begin
                            go_err = 1'b1;
                            err_c  = E_CSUM;
                        end
                    end
                end
            end
            S_DONE, S_ERR: state_d = bus.enable ? S_HUNT : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (go_err) begin
            state_d = S_ERR;
            code_d  = err_c;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    assign busy_d = state_d inside {S_LEN, S_PAYLOAD, S_CSUM};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rx_en_q <= 1'b0;
            rxv_q   <= 1'b0;
            baud_q  <= 3'b111;
            cnt_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_en_q <= bus.enable;
            rxv_q   <= bus.Rx_VALID;
            // Baud may only change while the receiver is fully quiesced.
            if (bus.cfg_load && !bus.enable && !rx_en_q) baud_q <= bus.cfg_baud;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.baud_select = baud_q;
    assign bus.Rx_EN       = rx_en_q;
    assign bus.pkt_data    = data_q;
    assign bus.pkt_valid   = valid_q;
    assign bus.pkt_last    = last_q;
    assign bus.pkt_done    = done_q;
    assign bus.pkt_err     = err_q;
    assign bus.err_code    = code_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Receive-side controller that sequences uart_receiver.
- Drives the receiver's Rx_EN and baud_select.
- Edge-detects Rx_VALID and assembles received bytes into framed packets: SYNC, LEN, LEN payload bytes, XOR checksum.
- Forwards payload bytes on a valid/ready stream and reports packet completion or errors.
- Sits between uart_receiver and the consumer of receive data.

Parameters:
SYNC_BYTE, 8'hAA, header byte that opens a packet
MAX_LEN, 16, maximum legal payload length (1..255)
TIMEOUT_CYCLES, 200000, max clk cycles between bytes inside a packet (used only with TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (reset=0 resets)
enable  in  1  master receive enable
cfg_baud  in  3  new baud code
cfg_load  in  1  load cfg_baud into baud_select
baud_select  out  3  to uart_receiver
Rx_EN  out  1  to uart_receiver
Rx_DATA  in  8  from uart_receiver
Rx_VALID  in  1  from uart_receiver (level or pulse)
Rx_FERROR  in  1  from uart_receiver
Rx_PERROR  in  1  from uart_receiver
pkt_data  out  8  payload byte
pkt_valid  out  1  pkt_data valid
pkt_ready  in  1  consumer accepts byte
pkt_last  out  1  qualifies final payload byte
pkt_done  out  1  1-cycle pulse, packet good
pkt_err  out  1  1-cycle pulse, packet aborted
err_code  out  2  00 line, 01 length, 10 checksum, 11 overrun/timeout/abort; held until next pkt_err
busy  out  1  high in LEN/PAYLOAD/CSUM

Behaviour:
Reset values:
- baud_select=3'b111.
- Rx_EN, pkt_valid, pkt_last, pkt_done, pkt_err, busy = 0.
- err_code=00, pkt_data=0, FSM in IDLE.

Enable and configuration:
- Rx_EN is enable registered (1-cycle latency).
- cfg_load is honoured only while enable=0 and Rx_EN=0; otherwise it is ignored. baud_select updates on the next edge.

Byte events:
- byte_evt = Rx_VALID & ~Rx_VALID_q (registered previous value).
- Rx_FERROR/Rx_PERROR are sampled in the byte_evt cycle.
- All outputs are registered and update on the byte_evt edge.

FSM:
- IDLE: Rx_EN=1 -> HUNT.
- HUNT: on byte_evt with no line error and Rx_DATA==SYNC_BYTE -> LEN. Other bytes and line-errored bytes are ignored.
- LEN: byte_evt with LEN==0 or LEN>MAX_LEN -> ERR(01). Otherwise store cnt=LEN, csum=LEN -> PAYLOAD.
- PAYLOAD: on byte_evt:
  - pkt_data<=Rx_DATA, pkt_valid<=1, csum^=Rx_DATA, cnt-=1.
  - pkt_last<=1 when cnt was 1; then -> CSUM.
- CSUM: byte_evt with Rx_DATA==csum -> DONE, else ERR(10).
- DONE: pkt_done=1 for 1 cycle -> HUNT.
- ERR: pkt_err=1 for 1 cycle, err_code set -> HUNT. pkt_valid and pkt_last clear on entry.
- Line error on any byte_evt in LEN/PAYLOAD/CSUM -> ERR(00).

Output handshake and boundaries:
- pkt_valid holds until pkt_valid&pkt_ready; the byte then clears on that edge.
- byte_evt in PAYLOAD while pkt_valid=1 and pkt_ready=0 -> ERR(11). The pending byte is dropped.
- Payload is forwarded before checksum verification. The consumer discards the packet on pkt_err.
- enable falling in LEN/PAYLOAD/CSUM -> ERR(11), then IDLE.
- enable falling in HUNT -> IDLE silently.
- Simultaneous pkt_ready handshake and byte_evt in PAYLOAD: the handshake completes and the new byte loads the same edge; no overrun.
- Reset mid-packet: immediate return to reset values; no pulses.

Optional Feature:
UART_RX_TIMEOUT_EN:
- Defined: a 32-bit counter clears on every byte_evt and on entry to LEN, and increments in LEN/PAYLOAD/CSUM. Reaching TIMEOUT_CYCLES -> ERR(11).
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Test Plan:
- Reset low 20 ns, enable=1, bytes AA 03 11 22 33 03 with pkt_ready=1 -> pkt_data 11,22,33 in order, pkt_last with 33, pkt_done pulse, err_code 00, no pkt_err.
- Bytes AA 03 11 22 33 04 -> three payload bytes forwarded, then pkt_err, err_code=10.
- Bytes 55 AA 00 -> 55 ignored, then pkt_err, err_code=01; following AA 01 7E 7F -> pkt_done.
- Bytes AA 02 10, with Rx_PERROR=1 on the third byte -> pkt_err, err_code=00, no pkt_valid for that byte.
- pkt_ready=0, bytes AA 02 10 20 -> pkt_data=10 held, then pkt_err, err_code=11 on the 20 event.
- enable=1 then cfg_load=1 with cfg_baud=3'b010 -> baud_select stays 111; enable=0 for 2 cycles then cfg_load -> baud_select=010.
